ddr5_request_queue: RTL

- Intake stage directly upstream of the DDR5 scheduler: accepts CPU memory requests (trace time, core, operation, 36-bit physical address).
- Decodes each address into the DDR5 topological fields and buffers the request in an in-order queue with per-entry aging.
- Presents the oldest request to the scheduler through a valid/pop interface.
- Queue depth matches the scheduler's 16-entry request queue limit.

---
 rtl/ddr5_request_queue.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ddr5_request_queue.sv
// In-order DDR5 request intake queue: decodes addresses at write time, ages entries, presents the oldest to the scheduler.
// Optional QUEUE_STATS_EN macro enables accepted/popped/high-water statistics counters.
module ddr5_request_queue #(
   parameter int DEPTH         = 16,
   parameter int AGE_W         = 16,
   parameter int STARVE_THRESH = 1000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [31:0]              req_time,
   input  logic [3:0]               req_core,
   input  logic [1:0]               req_op,
   input  logic [35:0]              req_addr,
   output logic                     head_valid,
   input  logic                     head_pop,
   output logic [31:0]              head_time,
   output logic [3:0]               head_core,
   output logic [1:0]               head_op,
   output logic [15:0]              head_row,
   output logic [5:0]               head_col_high,
   output logic [1:0]               head_bank,
   output logic [2:0]               head_bank_group,
   output logic                     head_channel,
   output logic [3:0]               head_col_low,
   output logic [1:0]               head_byte_sel,
   output logic [AGE_W-1:0]         head_age,
   output logic                     head_starved,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err_illegal_op,
   output logic [31:0]              stat_accepted,
   output logic [31:0]              stat_popped,
   output logic [$clog2(DEPTH):0]   stat_high_water
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [DEPTH-1:0] r_vld;
   logic [AGE_W-1:0] r_age [DEPTH];
   logic             r_err;

   logic [31:0] r_time     [DEPTH];
   logic [3:0]  r_core     [DEPTH];
   logic [1:0]  r_op       [DEPTH];
   logic [15:0] r_row      [DEPTH];
   logic [5:0]  r_col_high [DEPTH];
   logic [1:0]  r_bank     [DEPTH];
   logic [2:0]  r_bg       [DEPTH];
   logic        r_channel  [DEPTH];
   logic [3:0]  r_col_low  [DEPTH];
   logic [1:0]  r_byte_sel [DEPTH];

   logic          w_head_valid;
   logic          w_push;
   logic          w_store;
   logic          w_pop;
   logic [CW-1:0] w_count_nxt;
   logic [63:0]   w_age_ext;
   logic          w_unused_addr;

   // Top two address bits are beyond the decoded topology.
   assign w_unused_addr = ^req_addr[35:34];

   assign w_head_valid = (r_count != '0);
   assign req_ready    = (r_count < CW'(DEPTH));
   assign w_push       = req_valid && req_ready;
   assign w_store      = w_push && (req_op != 2'd3);
   assign w_pop        = head_pop && w_head_valid;

   always_comb begin
      w_count_nxt = r_count;
      unique case ({w_store, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_vld    <= '0;
         r_err    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
      end else begin
         r_err   <= w_push && (req_op == 2'd3);
         r_count <= w_count_nxt;
         if (w_store) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
         // A slot is written only when not full, so it never collides with the head being popped.
         for (int i = 0; i < DEPTH; i++) begin
            if (w_store && (r_wr_ptr == PW'(i))) begin
               r_vld[i] <= 1'b1;
               r_age[i] <= '0;
            end else if (w_pop && (r_rd_ptr == PW'(i))) begin
               r_vld[i] <= 1'b0;
            end else if (r_vld[i] && (r_age[i] != {AGE_W{1'b1}})) begin
               r_age[i] <= r_age[i] + 1'b1;
            end
         end
      end
   end

   // Payload storage: address split into DDR5 fields at write time.
   always_ff @(posedge clk) begin
      if (w_store) begin
         r_time[r_wr_ptr]     <= req_time;
         r_core[r_wr_ptr]     <= req_core;
         r_op[r_wr_ptr]       <= req_op;
         r_row[r_wr_ptr]      <= req_addr[33:18];
         r_col_high[r_wr_ptr] <= req_addr[17:12];
         r_bank[r_wr_ptr]     <= req_addr[11:10];
         r_bg[r_wr_ptr]       <= req_addr[9:7];
         r_channel[r_wr_ptr]  <= req_addr[6];
         r_col_low[r_wr_ptr]  <= req_addr[5:2];
         r_byte_sel[r_wr_ptr] <= req_addr[1:0];
      end
   end

   assign head_valid      = w_head_valid;
   assign count           = r_count;
   assign err_illegal_op  = r_err;
   assign head_time       = w_head_valid ? r_time[r_rd_ptr]     : '0;
   assign head_core       = w_head_valid ? r_core[r_rd_ptr]     : '0;
   assign head_op         = w_head_valid ? r_op[r_rd_ptr]       : '0;
   assign head_row        = w_head_valid ? r_row[r_rd_ptr]      : '0;
   assign head_col_high   = w_head_valid ? r_col_high[r_rd_ptr] : '0;
   assign head_bank       = w_head_valid ? r_bank[r_rd_ptr]     : '0;
   assign head_bank_group = w_head_valid ? r_bg[r_rd_ptr]       : '0;
   assign head_channel    = w_head_valid ? r_channel[r_rd_ptr]  : 1'b0;
   assign head_col_low    = w_head_valid ? r_col_low[r_rd_ptr]  : '0;
   assign head_byte_sel   = w_head_valid ? r_byte_sel[r_rd_ptr] : '0;
   assign head_age        = w_head_valid ? r_age[r_rd_ptr]      : '0;

   assign w_age_ext    = 64'(head_age);
   assign head_starved = w_head_valid && (w_age_ext >= 64'(STARVE_THRESH));

`ifdef QUEUE_STATS_EN
   logic [31:0]   r_stat_acc;
   logic [31:0]   r_stat_pop;
   logic [CW-1:0] r_stat_hw;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_acc <= '0;
         r_stat_pop <= '0;
         r_stat_hw  <= '0;
      end else begin
         if (w_store) r_stat_acc <= r_stat_acc + 1'b1;
         if (w_pop)   r_stat_pop <= r_stat_pop + 1'b1;
         if (w_count_nxt > r_stat_hw) r_stat_hw <= w_count_nxt;
      end
   end

   assign stat_accepted   = r_stat_acc;
   assign stat_popped     = r_stat_pop;
   assign stat_high_water = r_stat_hw;
`else
   assign stat_accepted   = '0;
   assign stat_popped     = '0;
   assign stat_high_water = '0;
`endif

endmodule
